// File: rtl/sumador_4b.sv
// sumador_4b: two-stage pipelined unsigned adder.
//   Stage 1 captures a/b, stage 2 captures their sum onto c.
//   Enable freezes both stages; synchronous active-low reset clears them.
//   Build option SUMADOR_SATURATE_EN: clamp overflowing sums to all-ones
//   instead of wrapping (default build wraps modulo 2^WIDTH).
module sumador_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] sum;

    // Sum of the stage-1 operands, wrapped or clamped depending on the build
    always_comb begin
`ifdef SUMADOR_SATURATE_EN
        logic [WIDTH:0] sum_full;
        sum_full = {1'b0, a_q} + {1'b0, b_q};
        sum      = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
        sum      = a_q + b_q;
`endif
    end

    // Next-state: both stages advance together only on enabled edges
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        if (enb) begin
            a_d = a;
            b_d = b;
            c_d = sum;
        end
    end

    // Pipeline registers; reset wins over enable and discards in-flight data
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
        end
    end

    assign c = c_q;

endmodule

// File: tb/tb_sumador_4b.sv
// Testbench for sumador_4b: randomized stimulus against a queue-based
// reference of the operand pairs sampled on enabled edges.
module tb_sumador_4b;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enb = 1'b1;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic [W-1:0] c;

    int errors = 0;
    int checks = 0;

    // reference state: operand pairs accepted since reset, result expected on c
    logic [2*W-1:0] hist[$];
    logic [W-1:0]   exp_c;

    sumador_4b #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .enb(enb),
        .a  (a),
        .b  (b),
        .c  (c)
    );

    always #5 clk = ~clk;

    function automatic int ref_sum(input int x, input int y);
`ifdef SUMADOR_SATURATE_EN
        return (x + y > MAXV) ? MAXV : x + y;
`else
        return (x + y) % (MAXV + 1);
`endif
    endfunction

    // One rising edge: update the reference from the inputs seen at the edge,
    // then step 1 time unit past the edge so outputs can be sampled.
    task automatic tick();
        logic [2*W-1:0] p;
        @(posedge clk);
        if (!rst) begin
            hist = {};
            hist.push_back('0);
            exp_c = '0;
        end else if (enb) begin
            hist.push_back({a, b});
            // the result shown is the pair accepted one enabled edge earlier
            p = hist[hist.size() - 2];
            exp_c = W'(ref_sum(int'(p[2*W-1:W]), int'(p[W-1:0])));
            while (hist.size() > 2) void'(hist.pop_front());
        end
        #1;
    endtask

    task automatic check_model(input string name);
        checks++;
        if ($isunknown(c) || c !== exp_c) begin
            errors++;
            $display("FAIL %s: c=%0d expected %0d", name, c, exp_c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; enb = 1'b1; a = 4'd5; b = 4'd3;
        tick();
        checks++;
        if (c !== 4'd0) begin errors++; $display("FAIL reset_edge1: c=%0d expected 0", c); end
        tick();
        checks++;
        if (c !== 4'd0) begin errors++; $display("FAIL reset_edge2: c=%0d expected 0", c); end
        rst = 1'b1;
        tick();
        checks++;
        if (c !== 4'd0) begin errors++; $display("FAIL reset_release1: c=%0d expected 0", c); end
        tick();
        checks++;
        if (c !== 4'd8) begin errors++; $display("FAIL reset_release2: c=%0d expected 8", c); end
        check_model("reset_model");
    endtask

    task automatic test_latency();
        enb = 1'b1;
        a = 4'd2; b = 4'd3;
        tick();
        a = 4'd7; b = 4'd1;
        tick();
        checks++;
        if (c !== 4'd5) begin errors++; $display("FAIL latency_first: c=%0d expected 5", c); end
        tick();
        checks++;
        if (c !== 4'd8) begin errors++; $display("FAIL latency_second: c=%0d expected 8", c); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] e1, e2;
`ifdef SUMADOR_SATURATE_EN
        e1 = 4'd15; e2 = 4'd15;
`else
        e1 = 4'd1;  e2 = 4'd0;
`endif
        enb = 1'b1;
        a = 4'd9; b = 4'd8;
        tick();
        a = 4'd15; b = 4'd1;
        tick();
        checks++;
        if (c !== e1) begin errors++; $display("FAIL overflow_9p8: c=%0d expected %0d", c, e1); end
        tick();
        checks++;
        if (c !== e2) begin errors++; $display("FAIL overflow_15p1: c=%0d expected %0d", c, e2); end
    endtask

    task automatic test_stall();
        logic [W-1:0] held;
        enb = 1'b1;
        a = 4'd4; b = 4'd4;
        tick();
        held = c;
        enb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom);
            tick();
            checks++;
            if (c !== held) begin errors++; $display("FAIL stall_hold%0d: c=%0d expected %0d", i, c, held); end
        end
        enb = 1'b1;
        a = 4'd1; b = 4'd2;
        tick();
        checks++;
        if (c !== 4'd8) begin errors++; $display("FAIL stall_resume: c=%0d expected 8", c); end
        a = 4'd0; b = 4'd0;
        tick();
        checks++;
        if (c !== 4'd3) begin errors++; $display("FAIL stall_next: c=%0d expected 3", c); end
    endtask

    task automatic test_mid_reset();
        enb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom); b = W'($urandom);
            tick();
            check_model("midrst_pre");
        end
        rst = 1'b0;
        a = W'($urandom); b = W'($urandom);
        tick();
        checks++;
        if (c !== 4'd0) begin errors++; $display("FAIL midrst_clear: c=%0d expected 0", c); end
        rst = 1'b1;
        a = W'($urandom); b = W'($urandom);
        tick();
        checks++;
        if (c !== 4'd0) begin errors++; $display("FAIL midrst_flushed: c=%0d expected 0", c); end
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom); b = W'($urandom);
            tick();
            check_model("midrst_post");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            enb = ($urandom_range(0, 3) != 0);
            tick();
            check_model("random");
        end
        enb = 1'b1;
    endtask

    initial begin
        hist.push_back('0);
        exp_c = '0;
        test_reset();
        test_latency();
        test_overflow();
        test_stall();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
